uart_rx: RTL and testbench
==========================

// Module: uart_rx
//
// PURPOSE
//  Asynchronous serial receiver, 8N1 by default, that deserialises the rx line into parallel bytes.
//  Consumes the 16x-oversample 'tick' from baud_rate_generator (M=651 gives 9600 baud at 100 MHz).
//  Sits between the board RX pin and the byte-stream consumer (RLE decode / FIFO).
//  Emits a one-cycle rx_done strobe per frame, with data and error flags.
//
// PARAMETERS
//  DBITS       8    data bits per frame, LSB first
//  SB_TICK     16   ticks spent in stop bit (16 = 1 stop bit, 32 = 2)
//  PARITY_ODD  0    parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd
//
// PORTS
//  clk_100MHz  in   1        system clock
//  reset       in   1        asynchronous, active-high
//  tick        in   1        1-cycle sample strobe, 16 per bit period
//  rx          in   1        serial line, idle high, asynchronous to clk
//  rx_data     out  DBITS    last received byte; held until the next rx_done
//  rx_done     out  1        1-cycle pulse: rx_data valid
//  frame_err   out  1        1-cycle pulse with rx_done: stop bit sampled low
//  parity_err  out  1        1-cycle pulse with rx_done: parity mismatch (0 when feature off)
//
// BEHAVIOUR
//  - Synchroniser: rx passes through 2 flops (reset value 1); all logic uses rx_s.
//  - Reset: state=IDLE; s, n, shift reg, rx_data=0; rx_done, frame_err, parity_err=0.
//  - s = 4-bit tick counter. n = bit counter, $clog2(DBITS) bits. Both advance only on tick.
//  - IDLE: rx_s==0 -> START, s=0. No tick is required to leave IDLE.
//  - START: on tick, s==7 (mid start bit): rx_s==0 -> DATA, s=0, n=0;
//    rx_s==1 -> IDLE (glitch rejected, no strobe). Otherwise s++.
//  - DATA: on tick, s==15: s=0, b={rx_s,b[DBITS-1:1]}; n==DBITS-1 -> PARITY/STOP, else n++.
//  - PARITY (macro only): on tick, s==15: s=0, latch rx_s as parity bit, -> STOP.
//  - STOP: on tick, s==SB_TICK-1: -> IDLE. Registered on the next clock edge:
//    rx_data<=b, rx_done=1, frame_err=~rx_s, parity_err per macro. Otherwise s++.
//  - Framing error still delivers the byte: rx_done=1 together with frame_err=1.
//  - Strobes are high for exactly one clk_100MHz cycle, never two in a row.
//  - Back-to-back frames: a start bit that follows the stop-bit sample directly is accepted.
//  - Reset mid-frame aborts the frame with no strobe.
//  - After reset, rx_s is 1. A line that is still low once the synchroniser fills is treated as a start bit.
//  - No tick arriving: the FSM freezes in its current state. No timeout.
//
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//  - A parity bit follows the data bits (state PARITY).
//  - parity_err = (^b ^ parity_bit) != PARITY_ODD, valid with rx_done.
//  UART_RX_PARITY_EN undefined:
//  - No PARITY state; STOP follows DATA directly.
//  - parity_err is tied to 0. The port list is unchanged.
//
// TESTING  (tick every 651 clks; bit = 16 ticks = 10416 clks)
//  1 Frame 0x55, 8N1          -> one rx_done, rx_data=0x55, frame_err=0, parity_err=0.
//  2 0xA3 then 0x0F, no idle gap -> two rx_done pulses, data 0xA3 then 0x0F, no errors.
//  3 rx low for 3 ticks, then high; then frame 0x81
//                             -> no strobe from the glitch; 0x81 received correctly.
//  4 Data 0xFF with stop bit driven low
//                             -> rx_done=1 and frame_err=1 in the same cycle, rx_data=0xFF.
//    Then idle high, frame 0x12 -> clean receive.
//  5 reset pulsed after 4 data bits of 0xC3
//                             -> no rx_done, all outputs 0.
//    Then full frame 0x3C     -> rx_data=0x3C.
//  6 [UART_RX_PARITY_EN, PARITY_ODD=0] 0x07 with parity 1 -> parity_err=0.
//    Same byte with parity 0  -> parity_err=1, rx_data=0x07.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled asynchronous serial receiver (8N1 by default), one rx_done strobe per frame.
// Optional parity bit enabled by defining UART_RX_PARITY_EN (sense chosen by PARITY_ODD).
module uart_rx #(
   parameter int DBITS      = 8,
   parameter int SB_TICK    = 16,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic             clk_100MHz,
   input  logic             reset,
   input  logic             tick,
   input  logic             rx,
   output logic [DBITS-1:0] rx_data,
   output logic             rx_done,
   output logic             frame_err,
   output logic             parity_err
);

   // state  | meaning
   // IDLE   | line idle high, waiting for a falling edge
   // START  | counting to mid start bit, rejects glitches
   // DATA   | sampling DBITS data bits, LSB first
   // PARITY | sampling the parity bit (parity build only)
   // STOP   | waiting out the stop bit, then strobing the result
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } state_t;

   // s grows beyond 4 bits only when more than one stop bit is configured
   localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;
   localparam logic [SW-1:0] S_MID  = SW'(7);
   localparam logic [SW-1:0] S_BIT  = SW'(15);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBITS - 1);

   logic             rx_m;
   logic             rx_s;
   state_t           state;
   logic [SW-1:0]    s;
   logic [NW-1:0]    n;
   logic [DBITS-1:0] b;
`ifdef UART_RX_PARITY_EN
   logic             par_bit;
`endif

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         s          <= '0;
         n          <= '0;
         b          <= '0;
         rx_data    <= '0;
         rx_done    <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit    <= 1'b0;
`endif
      end else begin
         rx_done    <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  state <= ST_START;
                  s     <= '0;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (s == S_MID) begin
                     if (!rx_s) begin
                        state <= ST_DATA;
                        s     <= '0;
                        n     <= '0;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (s == S_BIT) begin
                     s <= '0;
                     b <= {rx_s, b[DBITS-1:1]};
                     if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state <= ST_PARITY;
`else
                        state <= ST_STOP;
`endif
                     end else begin
                        n <= n + 1'b1;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (tick) begin
                  if (s == S_BIT) begin
                     s       <= '0;
                     par_bit <= rx_s;
                     state   <= ST_STOP;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
`endif
            ST_STOP: begin
               if (tick) begin
                  if (s == S_STOP) begin
                     state     <= ST_IDLE;
                     rx_data   <= b;
                     rx_done   <= 1'b1;
                     frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                     parity_err <= ((^b) ^ par_bit) != PARITY_ODD;
`else
                     parity_err <= PARITY_ODD & 1'b0;
`endif
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx, expected bytes queued and checked by a monitor on each rx_done.
// Build with UART_RX_PARITY_EN defined to also exercise the parity bit.
module tb_uart_rx;

   // tick divider shortened from 651 so the run stays brief; the DUT only sees the tick rate
   localparam int TICK_DIV = 8;
   localparam int BIT_CLKS = 16 * TICK_DIV;

   logic       clk_100MHz = 1'b0;
   logic       reset      = 1'b1;
   logic       tick       = 1'b0;
   logic       rx         = 1'b1;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
   logic       parity_err;

   uart_rx dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .tick       (tick),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_done    (rx_done),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   initial begin
      forever begin
         repeat (TICK_DIV - 1) @(posedge clk_100MHz);
         #1 tick = 1'b1;
         @(posedge clk_100MHz);
         #1 tick = 1'b0;
      end
   end

   typedef struct packed {
      logic [7:0] data;
      logic       ferr;
      logic       perr;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic prev_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic expect_frame(input logic [7:0] d, input logic ferr, input logic perr);
      exp_t x;
      x.data = d;
      x.ferr = ferr;
      x.perr = perr;
      sb.push_back(x);
   endtask

   task automatic line(input logic v, input int clks);
      rx = v;
      repeat (clks) @(posedge clk_100MHz);
      #1;
   endtask

   // stop_lo holds the stop bit low for 3/4 of a bit, so it is sampled low but the
   // line is back high before the false start that follows it is checked
   task automatic send_frame(input logic [7:0] d, input logic p, input logic stop_lo);
      line(1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) line(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
      line(p, BIT_CLKS);
`else
      if (p) line(1'b1, 0);
`endif
      if (stop_lo) begin
         line(1'b0, (BIT_CLKS * 3) / 4);
         line(1'b1, BIT_CLKS / 4);
      end else begin
         line(1'b1, BIT_CLKS);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk_100MHz);
         if (rx_done) begin
            chk("no_double_strobe", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_strobe: rx_data 0x%0h, required no strobe", rx_data);
            end else begin
               e = sb.pop_front();
               chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
               chk("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
               chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
            end
         end else if (frame_err || parity_err) begin
            chk("err_without_done", {30'd0, frame_err, parity_err}, 32'd0);
         end
         prev_done = rx_done;
      end
   end

   initial begin
      logic [7:0] part;
      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(posedge clk_100MHz);
      #1;
      chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
      chk("reset_rx_done", {31'd0, rx_done}, 32'd0);
      chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
      chk("reset_parity_err", {31'd0, parity_err}, 32'd0);
      reset = 1'b0;
      line(1'b1, 2 * BIT_CLKS);

      // single frame
      expect_frame(8'h55, 1'b0, 1'b0);
      send_frame(8'h55, 1'b0, 1'b0);
      line(1'b1, BIT_CLKS);

      // back-to-back frames, no idle gap
      expect_frame(8'hA3, 1'b0, 1'b0);
      send_frame(8'hA3, 1'b0, 1'b0);
      expect_frame(8'h0F, 1'b0, 1'b0);
      send_frame(8'h0F, 1'b0, 1'b0);
      line(1'b1, BIT_CLKS);

      // 3-tick glitch must not start a frame
      line(1'b0, 3 * TICK_DIV);
      line(1'b1, 2 * BIT_CLKS);
      expect_frame(8'h81, 1'b0, 1'b0);
      send_frame(8'h81, 1'b0, 1'b0);
      line(1'b1, BIT_CLKS);

      // framing error still delivers the byte
      expect_frame(8'hFF, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b0, 1'b1);
      line(1'b1, 2 * BIT_CLKS);
      expect_frame(8'h12, 1'b0, 1'b0);
      send_frame(8'h12, 1'b0, 1'b0);
      line(1'b1, BIT_CLKS);

      // reset after 4 data bits of 0xC3 aborts the frame
      part = 8'hC3;
      line(1'b0, BIT_CLKS);
      for (int i = 0; i < 4; i++) line(part[i], BIT_CLKS);
      rx    = 1'b1;
      reset = 1'b1;
      repeat (4) @(posedge clk_100MHz);
      #1;
      chk("abort_rx_data", {24'd0, rx_data}, 32'd0);
      chk("abort_rx_done", {31'd0, rx_done}, 32'd0);
      chk("abort_frame_err", {31'd0, frame_err}, 32'd0);
      chk("abort_parity_err", {31'd0, parity_err}, 32'd0);
      reset = 1'b0;
      line(1'b1, 2 * BIT_CLKS);
      expect_frame(8'h3C, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b0);
      line(1'b1, BIT_CLKS);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones: even parity bit 1 is correct, 0 is a mismatch
      expect_frame(8'h07, 1'b0, 1'b0);
      send_frame(8'h07, 1'b1, 1'b0);
      line(1'b1, BIT_CLKS);
      expect_frame(8'h07, 1'b0, 1'b1);
      send_frame(8'h07, 1'b0, 1'b0);
      line(1'b1, BIT_CLKS);
`endif

      line(1'b1, BIT_CLKS);
      chk("all_frames_received", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
